smem_console_writer: RTL and testbench
======================================

// Module: smem_console_writer
// PURPOSE
//  Writer side of the character screen memory scanned by the VGA display driver.
//  - Accepts a stream of character and console commands over a valid/ready handshake.
//  - Keeps a text cursor and writes 4-bit character codes into the screen memory write port.
//  - Performs newline, line wrap, full-screen clear and one-line scroll-up.
//  - Scrolling uses the memory's asynchronous read port.
// PARAMETERS
//  Ncols   40    characters per row (640/16)
//  Nrows   30    rows per screen (480/16)
//  Nloc    1200  screen memory locations (Ncols*Nrows)
//  Cbits   4     character code width
//  BLANK   0     character code written by clear/scroll fill
// PORTS
//  clk           in   1               system clock
//  reset         in   1               synchronous, active-high reset
//  in_valid      in   1               command/char present
//  in_ready      out  1               block can accept (state IDLE)
//  in_cmd        in   2               00 PUTC, 01 NEWLINE, 10 CLEAR, 11 HOME
//  in_char       in   Cbits           char code for PUTC
//  smem_we       out  1               screen memory write enable (registered)
//  smem_wr_addr  out  $clog2(Nloc)    write address (registered)
//  smem_wr_data  out  Cbits           write data (registered)
//  smem_rd_addr  out  $clog2(Nloc)    read address, used only while scrolling
//  smem_rd_data  in   Cbits           async read data for smem_rd_addr, same cycle
//  cur_row       out  $clog2(Nrows)   cursor row
//  cur_col       out  $clog2(Ncols)   cursor column
// BEHAVIOUR
//  Addressing
//  - Address = row*Ncols + col, identical to the display driver's mapping.
//  - No address ever reaches Nloc.
//  Handshake
//  - A transfer occurs on the clk edge where in_valid & in_ready.
//  - in_ready = (state==IDLE), combinational from state.
//  - Inputs are ignored otherwise, and in_valid may stay high while busy.
//  FSM: IDLE, CLEAR, SCR_COPY, SCR_FILL
//  - IDLE PUTC
//    - Next cycle: smem_we=1, wr_addr=cursor address, wr_data=in_char.
//    - Cursor advances: col+1. At col=Ncols-1: col=0, row+1.
//    - If the write was at (Nrows-1,Ncols-1): cursor becomes (Nrows-1,0) and the FSM goes to SCR_COPY.
//  - IDLE NEWLINE
//    - col=0. If row<Nrows-1, row+1.
//    - Else row is kept and the FSM goes to SCR_COPY. No write.
//  - IDLE HOME: cursor=(0,0). No write, stays IDLE.
//  - IDLE CLEAR
//    - Cursor=(0,0); go to CLEAR.
//    - Writes BLANK to addr 0..Nloc-1, one per cycle, ascending.
//    - Then IDLE. in_ready is low for exactly Nloc cycles.
//  - SCR_COPY
//    - Index i runs 0..Nloc-Ncols-1 with smem_rd_addr = i+Ncols.
//    - Next cycle: we=1, wr_addr=i, wr_data = the sampled rd_data.
//  - SCR_FILL
//    - Writes BLANK to Nloc-Ncols..Nloc-1, then IDLE.
//    - Whole scroll: in_ready low exactly Nloc cycles.
//  - smem_we is 0 in any cycle not listed above.
//  - smem_rd_addr is 0 outside SCR_COPY.
//  - A PUTC that triggers a scroll writes its char first, one cycle before the first copy write, so that char scrolls up.
//  Reset values
//  - state=IDLE, cursor=(0,0), in_ready=1, smem_we=0.
//  - wr_addr=0, wr_data=0, rd_addr=0.
//  - Reset mid-CLEAR or mid-scroll aborts at once. Memory is left partially updated; no pending write is issued.
//  Arithmetic
//  - Counters are $clog2(Nloc) bits wide. Terminal compare is equality, never overflow.
// TESTING
//  - Reset, then PUTC 1,2,3 back-to-back -> writes (0,1),(1,2),(2,3); cursor (0,3); in_ready stays 1.
//  - Cursor at (5,39), PUTC 7 -> write addr 239 data 7; cursor (6,0).
//  - Preload mem[40]=5, mem[1199]=9; cursor (29,0); NEWLINE ->
//    - in_ready low 1200 cycles.
//    - Then mem[0]=5, mem[1159]=9, mem[1160..1199]=0.
//    - Cursor (29,0).
//  - Cursor (29,39), PUTC 4 -> write addr 1199=4; after scroll mem[1159]=4; cursor (29,0).
//  - CLEAR with in_valid held high through busy -> 1200 BLANK writes to 0..1199.
//    - Exactly one CLEAR accepted; the next command is accepted on the first ready cycle.
//  - Reset asserted 100 cycles into a scroll -> next cycle: in_ready=1, smem_we=0, cursor (0,0).

Source files
------------

// File: rtl/smem_console_writer.sv
// Writer side of the character screen memory: turns a stream of console commands
// into cursor updates and screen memory writes, including clear and one-line scroll-up.
module smem_console_writer #(
  parameter int               Ncols = 40,
  parameter int               Nrows = 30,
  parameter int               Nloc  = Ncols * Nrows,
  parameter int               Cbits = 4,
  parameter logic [Cbits-1:0] BLANK = '0,
  localparam int              AW    = $clog2(Nloc),
  localparam int              RW    = $clog2(Nrows),
  localparam int              CW    = $clog2(Ncols)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_cmd,
  input  logic [Cbits-1:0] in_char,
  output logic             smem_we,
  output logic [AW-1:0]    smem_wr_addr,
  output logic [Cbits-1:0] smem_wr_data,
  output logic [AW-1:0]    smem_rd_addr,
  input  logic [Cbits-1:0] smem_rd_data,
  output logic [RW-1:0]    cur_row,
  output logic [CW-1:0]    cur_col
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CLEAR    = 2'd1;
  localparam logic [1:0] SCR_COPY = 2'd2;
  localparam logic [1:0] SCR_FILL = 2'd3;

  localparam logic [1:0] CMD_PUTC    = 2'b00;
  localparam logic [1:0] CMD_NEWLINE = 2'b01;
  localparam logic [1:0] CMD_CLEAR   = 2'b10;
  localparam logic [1:0] CMD_HOME    = 2'b11;

  localparam logic [AW-1:0] ROW_STRIDE = AW'(Ncols);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(Nloc - 1);
  localparam logic [AW-1:0] COPY_LAST  = AW'(Nloc - Ncols - 1);
  localparam logic [AW-1:0] FILL_FIRST = AW'(Nloc - Ncols);
  localparam logic [RW-1:0] LAST_ROW   = RW'(Nrows - 1);
  localparam logic [CW-1:0] LAST_COL   = CW'(Ncols - 1);

  logic [1:0]    state;
  logic [AW-1:0] idx;
  logic [AW-1:0] cursor_addr;

  assign in_ready    = (state == IDLE);
  assign cursor_addr = AW'(cur_row) * ROW_STRIDE + AW'(cur_col);

  // The copy reads one row below the location it writes next cycle.
  assign smem_rd_addr = (state == SCR_COPY) ? idx + ROW_STRIDE : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      cur_row      <= '0;
      cur_col      <= '0;
      smem_we      <= 1'b0;
      smem_wr_addr <= '0;
      smem_wr_data <= '0;
    end else begin
      smem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            case (in_cmd)
              CMD_PUTC: begin
                smem_we      <= 1'b1;
                smem_wr_addr <= cursor_addr;
                smem_wr_data <= in_char;
                if (cur_col == LAST_COL) begin
                  cur_col <= '0;
                  // Writing the bottom-right cell scrolls; the char lands before the copy starts.
                  if (cur_row == LAST_ROW) begin
                    state <= SCR_COPY;
                    idx   <= '0;
                  end else begin
                    cur_row <= cur_row + 1'b1;
                  end
                end else begin
                  cur_col <= cur_col + 1'b1;
                end
              end
              CMD_NEWLINE: begin
                cur_col <= '0;
                if (cur_row == LAST_ROW) begin
                  state <= SCR_COPY;
                  idx   <= '0;
                end else begin
                  cur_row <= cur_row + 1'b1;
                end
              end
              CMD_CLEAR: begin
                cur_row <= '0;
                cur_col <= '0;
                state   <= CLEAR;
                idx     <= '0;
              end
              CMD_HOME: begin
                cur_row <= '0;
                cur_col <= '0;
              end
              default: ;
            endcase
          end
        end
        CLEAR: begin
          smem_we      <= 1'b1;
          smem_wr_addr <= idx;
          smem_wr_data <= BLANK;
          if (idx == LAST_ADDR) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        SCR_COPY: begin
          smem_we      <= 1'b1;
          smem_wr_addr <= idx;
          smem_wr_data <= smem_rd_data;
          if (idx == COPY_LAST) begin
            state <= SCR_FILL;
            idx   <= FILL_FIRST;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        SCR_FILL: begin
          smem_we      <= 1'b1;
          smem_wr_addr <= idx;
          smem_wr_data <= BLANK;
          if (idx == LAST_ADDR) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_smem_console_writer.sv
// Directed bench for smem_console_writer with a behavioural screen memory
// (synchronous write, asynchronous read) attached to the DUT ports.
module tb_smem_console_writer;

  localparam logic [1:0] PUTC    = 2'b00;
  localparam logic [1:0] NEWLINE = 2'b01;
  localparam logic [1:0] CLR     = 2'b10;
  localparam logic [1:0] HOME    = 2'b11;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_cmd;
  logic [3:0]  in_char;
  logic        smem_we;
  logic [10:0] smem_wr_addr;
  logic [3:0]  smem_wr_data;
  logic [10:0] smem_rd_addr;
  logic [3:0]  smem_rd_data;
  logic [4:0]  cur_row;
  logic [5:0]  cur_col;

  logic [3:0]  mem [0:1199];
  logic        pre_en;
  logic [10:0] pre_addr;
  logic [3:0]  pre_data;

  int check_count;
  int pass_count;

  smem_console_writer dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_cmd       (in_cmd),
    .in_char      (in_char),
    .smem_we      (smem_we),
    .smem_wr_addr (smem_wr_addr),
    .smem_wr_data (smem_wr_data),
    .smem_rd_addr (smem_rd_addr),
    .smem_rd_data (smem_rd_data),
    .cur_row      (cur_row),
    .cur_col      (cur_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Screen memory model; the bench-side port only preloads while the DUT is idle.
  always @(posedge clk) begin
    if (smem_we) mem[smem_wr_addr] <= smem_wr_data;
    else if (pre_en) mem[pre_addr] <= pre_data;
  end
  assign smem_rd_data = mem[smem_rd_addr];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] c, input logic [3:0] ch);
    in_valid = v;
    in_cmd   = c;
    in_char  = ch;
  endtask

  // Present one command for a single edge; returns at the negedge after acceptance.
  task automatic sendCmd(input logic [1:0] c, input logic [3:0] ch);
    applyStimulus(1'b1, c, ch);
    @(negedge clk);
    applyStimulus(1'b0, c, ch);
  endtask

  task automatic preload(input int a, input logic [3:0] d);
    pre_en   = 1'b1;
    pre_addr = 11'(a);
    pre_data = d;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (!in_ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int writes;
    int bad;
    check_count = 0;
    pass_count  = 0;
    pre_en   = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    reset    = 1'b1;
    applyStimulus(1'b0, PUTC, 4'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_ready", int'(in_ready), 1);
    checkOutput("rst_we", int'(smem_we), 0);
    checkOutput("rst_wr_addr", int'(smem_wr_addr), 0);
    checkOutput("rst_wr_data", int'(smem_wr_data), 0);
    checkOutput("rst_rd_addr", int'(smem_rd_addr), 0);
    checkOutput("rst_row", int'(cur_row), 0);
    checkOutput("rst_col", int'(cur_col), 0);

    // Back-to-back PUTC 1,2,3
    applyStimulus(1'b1, PUTC, 4'd1);
    @(negedge clk);
    checkOutput("putc1_we", int'(smem_we), 1);
    checkOutput("putc1_addr", int'(smem_wr_addr), 0);
    checkOutput("putc1_data", int'(smem_wr_data), 1);
    checkOutput("putc1_ready", int'(in_ready), 1);
    applyStimulus(1'b1, PUTC, 4'd2);
    @(negedge clk);
    checkOutput("putc2_addr", int'(smem_wr_addr), 1);
    checkOutput("putc2_data", int'(smem_wr_data), 2);
    applyStimulus(1'b1, PUTC, 4'd3);
    @(negedge clk);
    applyStimulus(1'b0, PUTC, 4'd0);
    checkOutput("putc3_addr", int'(smem_wr_addr), 2);
    checkOutput("putc3_data", int'(smem_wr_data), 3);
    checkOutput("putc3_ready", int'(in_ready), 1);
    checkOutput("putc3_col", int'(cur_col), 3);
    checkOutput("putc3_row", int'(cur_row), 0);
    @(negedge clk);
    checkOutput("idle_we", int'(smem_we), 0);

    // Line wrap from (5,39)
    sendCmd(HOME, 4'd0);
    checkOutput("home_col", int'(cur_col), 0);
    checkOutput("home_we", int'(smem_we), 0);
    for (int i = 0; i < 5; i++) sendCmd(NEWLINE, 4'd0);
    for (int i = 0; i < 39; i++) sendCmd(PUTC, 4'd0);
    checkOutput("pre_wrap_row", int'(cur_row), 5);
    checkOutput("pre_wrap_col", int'(cur_col), 39);
    sendCmd(PUTC, 4'd7);
    checkOutput("wrap_we", int'(smem_we), 1);
    checkOutput("wrap_addr", int'(smem_wr_addr), 239);
    checkOutput("wrap_data", int'(smem_wr_data), 7);
    checkOutput("wrap_row", int'(cur_row), 6);
    checkOutput("wrap_col", int'(cur_col), 0);

    // NEWLINE on the last row scrolls
    sendCmd(HOME, 4'd0);
    for (int i = 0; i < 29; i++) sendCmd(NEWLINE, 4'd0);
    checkOutput("nl_pre_row", int'(cur_row), 29);
    checkOutput("nl_pre_ready", int'(in_ready), 1);
    preload(40, 4'd5);
    preload(1199, 4'd9);
    sendCmd(NEWLINE, 4'd0);
    checkOutput("nl_busy", int'(in_ready), 0);
    checkOutput("nl_no_write", int'(smem_we), 0);
    checkOutput("nl_rd_addr", int'(smem_rd_addr), 40);
    waitIdle(n);
    checkOutput("nl_busy_cycles", n, 1200);
    checkOutput("nl_last_fill_addr", int'(smem_wr_addr), 1199);
    @(negedge clk);
    checkOutput("nl_mem0", int'(mem[0]), 5);
    checkOutput("nl_mem1159", int'(mem[1159]), 9);
    bad = 0;
    for (int a = 1160; a < 1200; a++) if (mem[a] !== 4'd0) bad++;
    checkOutput("nl_fill_nonzero", bad, 0);
    checkOutput("nl_row", int'(cur_row), 29);
    checkOutput("nl_col", int'(cur_col), 0);

    // PUTC at the bottom-right cell scrolls its own char up
    for (int i = 0; i < 39; i++) sendCmd(PUTC, 4'd0);
    checkOutput("br_pre_col", int'(cur_col), 39);
    sendCmd(PUTC, 4'd4);
    checkOutput("br_we", int'(smem_we), 1);
    checkOutput("br_addr", int'(smem_wr_addr), 1199);
    checkOutput("br_data", int'(smem_wr_data), 4);
    checkOutput("br_row", int'(cur_row), 29);
    checkOutput("br_col", int'(cur_col), 0);
    checkOutput("br_busy", int'(in_ready), 0);
    checkOutput("br_rd_addr", int'(smem_rd_addr), 40);
    waitIdle(n);
    checkOutput("br_busy_cycles", n, 1200);
    @(negedge clk);
    checkOutput("br_mem1159", int'(mem[1159]), 4);
    checkOutput("br_mem1199", int'(mem[1199]), 0);

    // CLEAR with in_valid held high; a PUTC waits behind it
    applyStimulus(1'b1, CLR, 4'd0);
    @(negedge clk);
    applyStimulus(1'b1, PUTC, 4'd6);
    checkOutput("clr_row", int'(cur_row), 0);
    checkOutput("clr_col", int'(cur_col), 0);
    n = 0;
    writes = 0;
    bad = 0;
    while (!in_ready && n < 2000) begin
      n++;
      if (smem_we) begin
        if (int'(smem_wr_addr) != writes || smem_wr_data !== 4'd0) bad++;
        writes++;
      end
      @(negedge clk);
    end
    if (smem_we) begin
      if (int'(smem_wr_addr) != writes || smem_wr_data !== 4'd0) bad++;
      writes++;
    end
    checkOutput("clr_busy_cycles", n, 1200);
    checkOutput("clr_writes", writes, 1200);
    checkOutput("clr_bad_writes", bad, 0);
    @(negedge clk);
    applyStimulus(1'b0, PUTC, 4'd0);
    checkOutput("after_clr_we", int'(smem_we), 1);
    checkOutput("after_clr_addr", int'(smem_wr_addr), 0);
    checkOutput("after_clr_data", int'(smem_wr_data), 6);
    checkOutput("after_clr_col", int'(cur_col), 1);
    checkOutput("after_clr_ready", int'(in_ready), 1);
    @(negedge clk);
    checkOutput("after_clr_idle_we", int'(smem_we), 0);

    // Reset 100 cycles into a scroll
    sendCmd(HOME, 4'd0);
    for (int i = 0; i < 29; i++) sendCmd(NEWLINE, 4'd0);
    sendCmd(NEWLINE, 4'd0);
    repeat (100) @(negedge clk);
    checkOutput("mid_busy", int'(in_ready), 0);
    checkOutput("mid_rd_addr", int'(smem_rd_addr), 140);
    checkOutput("mid_wr_addr", int'(smem_wr_addr), 99);
    checkOutput("mid_row", int'(cur_row), 29);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_ready", int'(in_ready), 1);
    checkOutput("abort_we", int'(smem_we), 0);
    checkOutput("abort_row", int'(cur_row), 0);
    checkOutput("abort_col", int'(cur_col), 0);
    checkOutput("abort_rd_addr", int'(smem_rd_addr), 0);
    @(negedge clk);
    checkOutput("abort_stays_idle", int'(in_ready), 1);
    checkOutput("abort_no_write", int'(smem_we), 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
